// File: rtl/iob_clint_tick_gen.sv
// ---------------------------------------------------------------------------
// iob_clint_tick_gen
//
// Produces the single-cycle timebase tick that advances the CLINT mtime
// counter. The tick source is either a programmable divider on clk or rising
// edges of the asynchronous rt_clk after synchronisation. A small
// memory-mapped register bus (valid/ready, same protocol as the CLINT)
// exposes the control, divisor and emitted-tick count registers.
//
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active-low
//   rt_clk   real-time clock, asynchronous to clk
//   valid    bus request
//   address  byte address (registers decoded on address[3:2])
//   wdata    write data
//   wstrb    write strobes; any bit set performs a full-word write
//   rdata    registered read data, valid while ready is high
//   ready    bus acknowledge, one cycle after valid
//   tick     one-clk timebase pulse to the CLINT mtime increment
//
// Register map:
//   0x0 CTRL     [0] enable, [1] src_sel (0 = clk divider, 1 = rt_clk edges)
//   0x4 DIV      [DIV_W-1:0] divisor, 0 behaves as 1
//   0x8 TICK_CNT 32-bit count of emitted ticks, writable, wraps
//   0xC reserved, reads 0, writes ignored
// ---------------------------------------------------------------------------
module iob_clint_tick_gen #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rt_clk,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic                  tick
);

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_DIV      = 2'd1,
    REG_TICK_CNT = 2'd2,
    REG_RSVD     = 2'd3
  } reg_sel_e;

  // Registers
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   en_q,       en_d;
  logic                   src_q,      src_d;
  logic [DIV_W-1:0]       div_q,      div_d;
  logic [31:0]            tick_cnt_q, tick_cnt_d;
  logic [DIV_W-1:0]       cnt_q,      cnt_d;
  logic                   tick_q,     tick_d;
  logic                   ready_q;
  logic [DATA_W-1:0]      rdata_q,    rdata_d;

  // Decode
  reg_sel_e         sel;
  logic             wr_en;
  logic             ctrl_wr;
  logic             div_wr;
  logic             tick_cnt_wr;
  logic             sync_out;
  logic             rise;
  logic             evt;
  logic [DIV_W-1:0] last_cnt;
  logic             unused_addr;

  assign sel         = reg_sel_e'(address[3:2]);
  assign wr_en       = valid & (|wstrb);
  assign ctrl_wr     = wr_en & (sel == REG_CTRL);
  assign div_wr      = wr_en & (sel == REG_DIV);
  assign tick_cnt_wr = wr_en & (sel == REG_TICK_CNT);
  assign unused_addr = ^address[1:0];

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign evt      = en_q & (src_q ? rise : 1'b1);

  // Divisor 0 is treated as 1, so the terminal count is 0 in both cases.
  assign last_cnt = (div_q == '0) ? '0 : div_q - DIV_W'(1);

  always_comb begin
    en_d       = en_q;
    src_d      = src_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    rdata_d    = '0;

    if (ctrl_wr) begin
      en_d  = wdata[0];
      src_d = wdata[1];
    end
    if (div_wr) begin
      div_d = wdata[DIV_W-1:0];
    end

    // A write on the same edge as a counted tick takes priority.
    if (tick_cnt_wr) begin
      tick_cnt_d = wdata[31:0];
    end else if (tick_q) begin
      tick_cnt_d = tick_cnt_q + 32'd1;
    end

    // Reconfiguration restarts the division and drops any coincident event.
    if (ctrl_wr || div_wr || !en_q) begin
      cnt_d = '0;
    end else if (evt) begin
      if (cnt_q == last_cnt) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    if (valid) begin
      case (sel)
        REG_CTRL:     rdata_d[1:0]       = {src_q, en_q};
        REG_DIV:      rdata_d[DIV_W-1:0] = div_q;
        REG_TICK_CNT: rdata_d[31:0]      = tick_cnt_q;
        default:      rdata_d            = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      en_q       <= 1'b1;
      src_q      <= 1'b0;
      div_q      <= DIV_W'(DEFAULT_DIV);
      tick_cnt_q <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // The synchroniser and edge detector run regardless of enable so that
      // enabling never observes a stale edge.
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rt_clk};
      prev_q     <= sync_out;
      en_q       <= en_d;
      src_q      <= src_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      ready_q    <= valid;
      rdata_q    <= rdata_d;
    end
  end

  assign tick  = tick_q;
  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_iob_clint_tick_gen.sv
module tb_iob_clint_tick_gen;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DEFAULT_DIV = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rt_clk = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        tick;

  always #5 clk = ~clk;

  iob_clint_tick_gen #(
    .ADDR_W      (4),
    .DATA_W      (32),
    .SYNC_STAGES (SYNC_STAGES),
    .DIV_W       (16),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rt_clk  (rt_clk),
    .valid   (valid),
    .address (address),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata),
    .ready   (ready),
    .tick    (tick)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: ticks occur when the number of qualifying events since
  // the last restart is a multiple of the effective divisor.
  bit          m_en, m_src;
  logic [15:0] m_div;
  logic [31:0] m_tcnt;
  longint unsigned m_ev;
  bit          m_tick, m_ready, m_was_read;
  logic [31:0] m_rdata;
  bit          rt_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_en = 1; m_src = 0; m_div = 16'(DEFAULT_DIV); m_tcnt = '0;
    m_ev = 0; m_tick = 0; m_ready = 0; m_rdata = '0; m_was_read = 0;
    rt_hist.delete();
    for (int i = 0; i <= int'(SYNC_STAGES); i++) rt_hist.push_back(1'b0);
  endtask

  task automatic model_step();
    bit rise, ev, new_tick, wr;
    int n;
    longint unsigned d;
    logic [1:0] sel;
    logic [31:0] rd;
    rt_hist.push_back(rt_clk);
    if (rt_hist.size() > SYNC_STAGES + 2) void'(rt_hist.pop_front());
    n = rt_hist.size();
    // rt_clk sampled SYNC_STAGES edges ago is 1 and the one before is 0
    rise = rt_hist[n-1-SYNC_STAGES] && !rt_hist[n-2-SYNC_STAGES];
    sel = address[3:2];
    wr = valid && (wstrb != 0);
    rd = '0;
    if (valid) begin
      if (sel == 2'd0) rd = {30'd0, m_src, m_en};
      else if (sel == 2'd1) rd = {16'd0, m_div};
      else if (sel == 2'd2) rd = m_tcnt;
    end
    d = (m_div == 0) ? 1 : longint'(m_div);
    ev = m_en && (m_src ? rise : 1'b1);
    new_tick = 0;
    if ((wr && sel < 2) || !m_en) m_ev = 0;
    else if (ev) begin
      m_ev++;
      new_tick = (m_ev % d) == 0;
    end
    if (wr && sel == 2'd2) m_tcnt = wdata;
    else if (m_tick) m_tcnt = m_tcnt + 1;
    if (wr && sel == 2'd0) begin m_en = wdata[0]; m_src = wdata[1]; end
    if (wr && sel == 2'd1) m_div = wdata[15:0];
    m_tick = new_tick;
    m_ready = valid;
    m_was_read = valid && (wstrb == 0);
    m_rdata = rd;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("tick", 32'(tick), 32'(m_tick));
    check("ready", 32'(ready), 32'(m_ready));
    if (m_was_read) check("rdata", rdata, m_rdata);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    model_reset();
    valid = 0; wstrb = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    cyc = 0;
  endtask

  task automatic bus(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = 1; address = a; wdata = d; wstrb = s;
    cycle();
    valid = 0; wstrb = '0;
  endtask

  task automatic read_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    bus(a, 32'd0, 4'h0);
    check({name, "_ready"}, 32'(ready), 32'd1);
    check(name, rdata, exp);
  endtask

  // Run until tick is seen, bounded; reports the number of edges taken.
  task automatic wait_tick(input string name, input int limit, output int taken);
    taken = 0;
    for (int i = 0; i < limit; i++) begin
      cycle();
      taken++;
      if (tick) return;
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic        v;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        exp_ready;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input string name, input logic v, input logic [3:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic chk, input logic [31:0] exp);
    vec_t r;
    r.name = name; r.v = v; r.a = a; r.d = d; r.s = s;
    r.exp_ready = v; r.chk = chk; r.exp = exp;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   ticks_at[$];
    int   nt, taken, rise_edge;

    model_reset();
    apply_reset();

    // Default divider: ticks at edges 1000, 2000, 3000 after release
    for (int i = 1; i <= 3000; i++) begin
      cycle();
      if (tick) ticks_at.push_back(i);
    end
    check("t1_nticks", 32'(ticks_at.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < ticks_at.size()) check("t1_tick_edge", 32'(ticks_at[k]), 32'(1000 * (k + 1)));
    cycle();
    read_chk("t1_tick_cnt", 4'h8, 32'd3);

    // Register access table, including the reserved address
    apply_reset();
    tbl.push_back(mk("ctrl_rst",  1, 4'h0, 32'h0,        4'h0, 1, 32'h1));
    tbl.push_back(mk("div_rst",   1, 4'h4, 32'h0,        4'h0, 1, 32'd1000));
    tbl.push_back(mk("tcnt_rst",  1, 4'h8, 32'h0,        4'h0, 1, 32'h0));
    tbl.push_back(mk("rsvd_rd",   1, 4'hC, 32'h0,        4'h0, 1, 32'h0));
    tbl.push_back(mk("rsvd_wr",   1, 4'hC, 32'hFFFFFFFF, 4'hF, 0, 32'h0));
    tbl.push_back(mk("rsvd_wr1",  1, 4'hC, 32'h12345678, 4'h1, 0, 32'h0));
    tbl.push_back(mk("ctrl_keep", 1, 4'h0, 32'h0,        4'h0, 1, 32'h1));
    tbl.push_back(mk("div_keep",  1, 4'h4, 32'h0,        4'h0, 1, 32'd1000));
    tbl.push_back(mk("tcnt_keep", 1, 4'h8, 32'h0,        4'h0, 1, 32'h0));
    tbl.push_back(mk("rsvd_rd2",  1, 4'hC, 32'h0,        4'h0, 1, 32'h0));
    tbl.push_back(mk("div_wr",    1, 4'h4, 32'hFFFF1234, 4'hF, 0, 32'h0));
    tbl.push_back(mk("div_upper", 1, 4'h4, 32'h0,        4'h0, 1, 32'h1234));
    tbl.push_back(mk("div_wstrb", 1, 4'h4, 32'h00000007, 4'h4, 0, 32'h0));
    tbl.push_back(mk("div_rd7",   1, 4'h4, 32'h0,        4'h0, 1, 32'h7));
    tbl.push_back(mk("ctrl_wr0",  1, 4'h0, 32'hFFFFFFFC, 4'h8, 0, 32'h0));
    tbl.push_back(mk("ctrl_rd0",  1, 4'h0, 32'h0,        4'h0, 1, 32'h0));
    tbl.push_back(mk("ctrl_wr3",  1, 4'h0, 32'h3,        4'hF, 0, 32'h0));
    tbl.push_back(mk("ctrl_rd3",  1, 4'h0, 32'h0,        4'h0, 1, 32'h3));
    tbl.push_back(mk("ctrl_wr1",  1, 4'h0, 32'h1,        4'hF, 0, 32'h0));
    tbl.push_back(mk("ctrl_rd1",  1, 4'h0, 32'h0,        4'h0, 1, 32'h1));
    tbl.push_back(mk("tcnt_wr",   1, 4'h8, 32'hDEADBEEF, 4'hF, 0, 32'h0));
    tbl.push_back(mk("tcnt_rd",   1, 4'h8, 32'h0,        4'h0, 1, 32'hDEADBEEF));
    tbl.push_back(mk("idle",      0, 4'h0, 32'h0,        4'h0, 0, 32'h0));
    foreach (tbl[i]) begin
      valid = tbl[i].v; address = tbl[i].a; wdata = tbl[i].d; wstrb = tbl[i].s;
      cycle();
      check({tbl[i].name, "_ready"}, 32'(ready), 32'(tbl[i].exp_ready));
      if (tbl[i].chk) check(tbl[i].name, rdata, tbl[i].exp);
    end
    valid = 0; wstrb = '0;

    // rt_clk source, DIV=1: one tick per rise, SYNC_STAGES+1 edges after sampling
    bus(4'h0, 32'h3, 4'hF);
    bus(4'h4, 32'h1, 4'hF);
    nt = 0; rise_edge = 0;
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < 32; k++) begin
        if (k == 0) begin rt_clk = 1; rise_edge = cyc + 1; end
        if (k == 16) rt_clk = 0;
        cycle();
        if (tick) begin
          nt++;
          check("t2_latency", 32'(cyc - rise_edge), 32'(SYNC_STAGES));
        end
      end
    end
    repeat (8) begin cycle(); if (tick) nt++; end
    check("t2_nticks", 32'(nt), 32'd10);

    // DIV=0 with clk source: tick every cycle
    bus(4'h0, 32'h1, 4'hF);
    bus(4'h4, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t3_tick_every", 32'(tick), 32'd1);
    end
    read_chk("t3_div0", 4'h4, 32'h0);

    // Disable mid-count, then re-enable: full period from the re-enable write
    bus(4'h4, 32'd1000, 4'hF);
    repeat (499) cycle();
    bus(4'h0, 32'h0, 4'hF);
    nt = 0;
    repeat (1200) begin cycle(); if (tick) nt++; end
    check("t4_no_tick_disabled", 32'(nt), 32'd0);
    bus(4'h0, 32'h1, 4'hF);
    wait_tick("t4_reenable", 1100, taken);
    check("t4_reenable_dist", 32'(taken), 32'd1000);

    // TICK_CNT wrap, and write winning over a coincident tick
    bus(4'h4, 32'd4, 4'hF);
    bus(4'h8, 32'hFFFFFFFF, 4'hF);
    wait_tick("t5_wrap", 10, taken);
    cycle();
    read_chk("t5_wrap_val", 4'h8, 32'h0);
    wait_tick("t5_coinc", 10, taken);
    bus(4'h8, 32'h5, 4'hF);
    read_chk("t5_write_wins", 4'h8, 32'h5);

    // Reset mid-count while a bus request is active
    bus(4'h4, 32'd1000, 4'hF);
    repeat (699) cycle();
    valid = 1; address = 4'h0; wstrb = '0;
    cycle();
    check("t6_ready_before", 32'(ready), 32'd1);
    apply_reset();
    read_chk("t6_ctrl", 4'h0, 32'h1);
    read_chk("t6_div", 4'h4, 32'd1000);
    wait_tick("t6_first", 1100, taken);
    check("t6_first_edge", 32'(cyc), 32'd1000);

    // Randomized traffic against the model, with a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      if ($urandom_range(0, 5) == 0) rt_clk = ~rt_clk;
      if ($urandom_range(0, 7) == 0) begin
        valid = 1;
        address = 4'($urandom_range(0, 3) << 2);
        wstrb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
        wdata = $urandom;
        if (address == 4'h4) wdata = 32'($urandom_range(0, 6));
        if (address == 4'h0) wdata[0] = ($urandom_range(0, 3) != 0);
      end else begin
        valid = 0; wstrb = '0;
      end
      cycle();
    end
    valid = 0; wstrb = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
